ofifo_drain: RTL
================

Name: ofifo_drain

Overview:
- Read-side controller for the per-column output psum FIFO bank behind the PE array.
- On a start command it pulls a programmed number of psum vectors (col × psum_bw) out of the FIFO bank and writes each one as a single word into psum SRAM at consecutive addresses.
- It then pulses done; the top-level controller uses done to sequence the next tile.

Parameters:
- col, 8, number of psum lanes per vector
- psum_bw, 16, bits per lane
- addr_bw, 11, psum SRAM address width
- rd_lat, 2, cycles from fifo_rd high to fifo_out valid (range 1..4)

Ports:
- clk  input  1  clock; all logic on posedge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  one-cycle command pulse; honoured only in IDLE
- base_addr  input  addr_bw  first SRAM address; latched on accepted start
- num_rows  input  addr_bw+1  vectors to drain; latched on accepted start
- fifo_valid  input  1  high when every lane FIFO holds at least one entry
- fifo_out  input  col*psum_bw  FIFO read data; lane i at bits [psum_bw*(i+1)-1 : psum_bw*i]
- fifo_rd  output  1  registered read strobe to FIFO bank
- sram_cen  output  1  SRAM chip enable, active-low, registered
- sram_wen  output  1  SRAM write enable, active-low, registered
- sram_addr  output  addr_bw  SRAM address, registered
- sram_din  output  col*psum_bw  SRAM write data, registered
- busy  output  1  high outside IDLE
- done  output  1  one-cycle pulse when the last write has been issued

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; fifo_rd=0, sram_cen=1, sram_wen=1, sram_addr=0, sram_din=0, busy=0, done=0.
  - issued/written counters = 0; inflight = 0.
- FSM states: IDLE, DRAIN, DONE.
- IDLE:
  - start=1 latches base_addr and num_rows and moves to DRAIN.
  - If num_rows=0, moves straight to DONE instead.
  - start while busy is ignored and does not relatch.
- DRAIN, read issue:
  - Issue when fifo_valid=1, inflight=0 and issued<num_rows.
  - fifo_rd goes high for exactly one cycle (cycle T); set inflight; issued++.
- DRAIN, capture:
  - At the end of cycle T+rd_lat, capture fifo_out and clear inflight.
  - During cycle T+rd_lat+1: sram_cen=0, sram_wen=0, sram_addr=base+written, sram_din=captured data; then written++.
  - All other DRAIN cycles: sram_cen=1, sram_wen=1; sram_addr and sram_din hold their last values.
- Throughput and ordering:
  - At most one outstanding read; peak rate is one vector per rd_lat+1 cycles.
  - The earliest next fifo_rd coincides with the write cycle of the previous vector.
- fifo_valid low: no read is issued; the FSM waits indefinitely. A read already in flight still completes.
- Address arithmetic:
  - base+written is computed modulo 2^addr_bw, so addresses wrap past all-ones to 0.
  - num_rows = 2^addr_bw is legal and writes every address once.
- DRAIN→DONE: in the cycle after the write of vector num_rows-1.
- DONE: done=1, busy=1 for one cycle, then IDLE (busy=0). A start arriving during DONE is ignored.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs at reset values.
  - Any in-flight FIFO data is dropped. The block does not drain or correct FIFO state; the bank is reset by the same reset.
- The block never asserts fifo_rd when fifo_valid was low in the previous cycle, and never issues more than num_rows reads per command.

Optional Feature:
- Macro: OFIFO_DRAIN_RELU_EN.
- Defined:
  - Each lane of the captured vector is treated as two's-complement psum_bw.
  - Negative lanes are replaced with 0 before loading sram_din. Non-negative lanes pass unchanged.
  - Latency and handshake timing are unchanged.
- Undefined: captured data is written to SRAM bit-exact.

Test Plan:
- Basic drain:
  - Stimulus: reset, then start with base_addr=0x010, num_rows=4; fifo_valid held 1; rd_lat=2; FIFO model returns vector k with lane i = 16*k+i.
  - Response: 4 fifo_rd pulses 3 cycles apart; writes to 0x010..0x013 with matching data; done pulses once 1 cycle after the last write; busy falls after done.
- Back-pressure:
  - Stimulus: num_rows=3; fifo_valid=0 for 10 cycles after start, then 1.
  - Response: no fifo_rd while fifo_valid=0; first fifo_rd within 1 cycle of fifo_valid rising; 3 writes total.
- Wrap-around:
  - Stimulus: base_addr=0x7FE, num_rows=4, addr_bw=11.
  - Response: writes to 0x7FE, 0x7FF, 0x000, 0x001 in that order.
- Zero / ignored start:
  - Stimulus: start with num_rows=0; then start pulsed again mid-DRAIN of a num_rows=2 job.
  - Response: first command gives done 1 cycle after start with no fifo_rd and no SRAM write; the second start has no effect (exactly 2 writes).
- Async reset mid-job:
  - Stimulus: reset driven low between a fifo_rd and its capture cycle in a num_rows=5 job.
  - Response: sram_cen=1, sram_wen=1, fifo_rd=0, busy=0 immediately, before the next clock edge; no done; a fresh start after release behaves as in the basic drain scenario.
- RELU (OFIFO_DRAIN_RELU_EN defined):
  - Stimulus: lane values 0x8000, 0xFFFF, 0x0000, 0x7FFF.
  - Response: written as 0x0000, 0x0000, 0x0000, 0x7FFF.
  - With the macro undefined, the same lanes are written unchanged.

Source files
------------

// File: rtl/ofifo_drain.sv
// ofifo_drain: moves a programmed number of psum vectors from the output FIFO bank into psum SRAM.
// Optional: define OFIFO_DRAIN_RELU_EN to clamp negative lanes to zero before the SRAM write.
module ofifo_drain #(
   parameter int unsigned Col    = 8,
   parameter int unsigned PsumBw = 16,
   parameter int unsigned AddrBw = 11,
   parameter int unsigned RdLat  = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic [AddrBw-1:0]       base_addr_i,
   input  logic [AddrBw:0]         num_rows_i,
   input  logic                    fifo_valid_i,
   input  logic [Col*PsumBw-1:0]   fifo_out_i,
   output logic                    fifo_rd_o,
   output logic                    sram_cen_o,
   output logic                    sram_wen_o,
   output logic [AddrBw-1:0]       sram_addr_o,
   output logic [Col*PsumBw-1:0]   sram_din_o,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam int unsigned      VecW    = Col * PsumBw;
   localparam logic [AddrBw:0]  RowOne  = 1;
   localparam logic [2:0]       LatOne  = 3'd1;
   localparam logic [2:0]       LatInit = 3'(RdLat);

   typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

   state_e            state_q;
   logic [AddrBw-1:0] base_q;
   logic [AddrBw:0]   num_q;
   logic [AddrBw:0]   issued_q;
   logic [AddrBw:0]   written_q;
   logic              inflight_q;
   logic [2:0]        lat_cnt_q;
   logic              fifo_rd_q;
   logic              cen_q;
   logic              wen_q;
   logic [AddrBw-1:0] addr_q;
   logic [VecW-1:0]   din_q;

   logic              capture;
   logic              issue;
   logic [AddrBw-1:0] wr_addr;
   logic [VecW-1:0]   cap_data;

   // A new read may launch on the same edge that retires the outstanding one.
   always_comb begin
      capture = (state_q == StDrain) && inflight_q && (lat_cnt_q == '0);
      issue   = (state_q == StDrain) && fifo_valid_i && (!inflight_q || capture) &&
                (issued_q < num_q);
      wr_addr = base_q + written_q[AddrBw-1:0];
   end

   always_comb begin
      cap_data = fifo_out_i;
`ifdef OFIFO_DRAIN_RELU_EN
      for (int i = 0; i < int'(Col); i++) begin
         if (fifo_out_i[PsumBw*i + PsumBw - 1]) begin
            cap_data[PsumBw*i +: PsumBw] = '0;
         end
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         base_q     <= '0;
         num_q      <= '0;
         issued_q   <= '0;
         written_q  <= '0;
         inflight_q <= 1'b0;
         lat_cnt_q  <= '0;
         fifo_rd_q  <= 1'b0;
         cen_q      <= 1'b1;
         wen_q      <= 1'b1;
         addr_q     <= '0;
         din_q      <= '0;
      end else begin
         fifo_rd_q <= 1'b0;
         cen_q     <= 1'b1;
         wen_q     <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  base_q     <= base_addr_i;
                  num_q      <= num_rows_i;
                  issued_q   <= '0;
                  written_q  <= '0;
                  inflight_q <= 1'b0;
                  lat_cnt_q  <= '0;
                  state_q    <= (num_rows_i == '0) ? StDone : StDrain;
               end
            end
            StDrain: begin
               if (issue) begin
                  fifo_rd_q  <= 1'b1;
                  issued_q   <= issued_q + RowOne;
                  inflight_q <= 1'b1;
                  lat_cnt_q  <= LatInit;
               end else if (capture) begin
                  inflight_q <= 1'b0;
               end else if (inflight_q) begin
                  lat_cnt_q  <= lat_cnt_q - LatOne;
               end
               if (capture) begin
                  din_q     <= cap_data;
                  addr_q    <= wr_addr;
                  cen_q     <= 1'b0;
                  wen_q     <= 1'b0;
                  written_q <= written_q + RowOne;
               end
               // written_q counts at capture, so equality here means the final write is on the bus.
               if ((written_q == num_q) && !inflight_q) begin
                  state_q <= StDone;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign fifo_rd_o   = fifo_rd_q;
   assign sram_cen_o  = cen_q;
   assign sram_wen_o  = wen_q;
   assign sram_addr_o = addr_q;
   assign sram_din_o  = din_q;
   assign busy_o      = (state_q != StIdle);
   assign done_o      = (state_q == StDone);

endmodule
